dmux_16_8w: RTL and testbench

- 1-to-8 sequential word distributor (deserializer) for 16-bit DSP samples; the inverse of the team's 8x1 16-bit word mux.
- Accepts one sample per cycle on a valid/ready input and steers it into one of eight registered output lanes.
- Lane selection is either an explicit select or an internal auto-incrementing pointer.
- Presents a completed 8-word frame to the downstream stage, holding it until acknowledged.

---
 rtl/dsp_pkg.sv | 22 ++
 rtl/dmux_lane_16.sv | 38 +++
 rtl/dmux_16_8w.sv | 129 ++++++++++++
 tb/tb_dmux_16_8w.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
//   Shared constants and types for the DSP sample-steering blocks.
//   N_LANES    : number of output lanes of the word distributor
//   W_DEF      : default sample width in bits
//   state_e    : frame FSM states (FILL = collecting samples, HOLD = frame
//                presented downstream, waiting for acknowledge)
//   LANES_FULL : lane-valid pattern that marks a complete frame
// ---------------------------------------------------------------------------
package dsp_pkg;

  localparam int N_LANES = 8;
  localparam int W_DEF   = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [N_LANES-1:0] LANES_FULL = 8'hFF;

endpackage : dsp_pkg

// File: rtl/dmux_lane_16.sv
// ---------------------------------------------------------------------------
// dmux_lane_16
//   One output lane of the word distributor: a W-bit register that loads d
//   when we is high and otherwise holds its value.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the lane to 0
//   we    : write enable
//   d     : sample to load
//   q     : registered lane value
// ---------------------------------------------------------------------------
module dmux_lane_16 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (we) q_d = d;
  end

  // NOTE: lane data is a handful of plain registers, not a RAM, so it takes
  // the async reset like any other flop and reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule : dmux_lane_16

// File: rtl/dmux_16_8w.sv
// ---------------------------------------------------------------------------
// dmux_16_8w
//   1-to-8 word distributor. Samples accepted on a valid/ready input are
//   steered into one of eight registered lanes, chosen either by s or by an
//   internal auto-incrementing pointer. Once all eight lanes hold a sample of
//   the current frame the block stops accepting, raises frame_vld and holds
//   the frame until o_ready. clr flushes the frame in progress.
//   clk, rst_n      : clock (rising edge), async active-low reset
//   i, i_valid      : input sample and its valid
//   i_ready         : high when a sample can be accepted this cycle
//   s, auto_en      : lane select (0 -> o1) and pointer-mode enable
//   clr             : synchronous frame flush, beats priority and o_ready
//   o1..o8          : registered lane outputs
//   lane_vld        : bit k set when o(k+1) holds a sample of this frame
//   frame_vld       : all lanes filled, frame stable
//   o_ready         : downstream takes the frame (only looked at in HOLD)
// ---------------------------------------------------------------------------
module dmux_16_8w
  import dsp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       i,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [2:0]         s,
  input  logic               auto_en,
  input  logic               clr,
  output logic [W-1:0]       o1,
  output logic [W-1:0]       o2,
  output logic [W-1:0]       o3,
  output logic [W-1:0]       o4,
  output logic [W-1:0]       o5,
  output logic [W-1:0]       o6,
  output logic [W-1:0]       o7,
  output logic [W-1:0]       o8,
  output logic [N_LANES-1:0] lane_vld,
  output logic               frame_vld,
  input  logic               o_ready
);

  state_e             state_d,    state_q;
  logic [2:0]         ptr_d,      ptr_q;
  logic [N_LANES-1:0] lane_vld_d, lane_vld_q;

  logic               accept;
  logic [2:0]         lane_sel;
  logic [N_LANES-1:0] lane_we;
  logic [W-1:0]       lane_q [N_LANES];

  // Gated with rst_n so the source never sees ready while reset is held.
  assign i_ready  = rst_n & (state_q == FILL);
  // clr drops any same-cycle beat, so it never reaches a lane register.
  assign accept   = i_valid & i_ready & ~clr;
  assign lane_sel = auto_en ? ptr_q : s;
  assign lane_we  = accept ? (N_LANES'(1) << lane_sel) : '0;

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lane_vld_d = lane_vld_q;

    if (clr) begin
      state_d    = FILL;
      ptr_d      = '0;
      lane_vld_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            // Rewriting an already-valid lane leaves its bit as it was.
            lane_vld_d = lane_vld_q | lane_we;
            if (auto_en) ptr_d = ptr_q + 3'd1;
            if (lane_vld_d == LANES_FULL) state_d = HOLD;
          end
        end
        HOLD: begin
          if (o_ready) begin
            state_d    = FILL;
            ptr_d      = '0;
            lane_vld_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order the simulator runs blocks in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      ptr_q      <= '0;
      lane_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lane_vld_q <= lane_vld_d;
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    dmux_lane_16 #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_we[k]),
      .d     (i),
      .q     (lane_q[k])
    );
  end

  assign o1 = lane_q[0];
  assign o2 = lane_q[1];
  assign o3 = lane_q[2];
  assign o4 = lane_q[3];
  assign o5 = lane_q[4];
  assign o6 = lane_q[5];
  assign o7 = lane_q[6];
  assign o8 = lane_q[7];

  assign lane_vld  = lane_vld_q;
  assign frame_vld = (state_q == HOLD);

endmodule : dmux_16_8w

// File: tb/tb_dmux_16_8w.sv
// ---------------------------------------------------------------------------
// tb_dmux_16_8w
//   Self-checking bench for dmux_16_8w. A frame-level reference model (lane
//   contents, per-lane valid flags, pointer, frame-held flag) tracks what the
//   outputs must show after every clock edge. Outputs are sampled 1 time
//   unit after the rising edge; inputs change at that point too.
// ---------------------------------------------------------------------------
module tb_dmux_16_8w;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  i;
  logic          i_valid;
  logic          i_ready;
  logic [2:0]    s;
  logic          auto_en;
  logic          clr;
  logic [W-1:0]  o1, o2, o3, o4, o5, o6, o7, o8;
  logic [7:0]    lane_vld;
  logic          frame_vld;
  logic          o_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmux_16_8w #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .s         (s),
    .auto_en   (auto_en),
    .clr       (clr),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .o4        (o4),
    .o5        (o5),
    .o6        (o6),
    .o7        (o7),
    .o8        (o8),
    .lane_vld  (lane_vld),
    .frame_vld (frame_vld),
    .o_ready   (o_ready)
  );

  logic [8*W-1:0] dut_bus;
  assign dut_bus = {o8, o7, o6, o5, o4, o3, o2, o1};

  // ---------------- reference model ----------------
  logic [W-1:0] m_lane [8];
  bit           m_vld  [8];
  int           m_ptr;
  bit           m_hold;
  logic [W-1:0] n_lane [8];
  bit           n_vld  [8];
  int           n_ptr;
  bit           n_hold;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_lane[k] = '0;
      m_vld[k]  = 1'b0;
    end
    m_ptr  = 0;
    m_hold = 1'b0;
  endtask

  // Next model state from the inputs present just before the clock edge.
  task automatic model_next();
    int filled;
    n_lane = m_lane;
    n_vld  = m_vld;
    n_ptr  = m_ptr;
    n_hold = m_hold;
    if (clr || (m_hold && o_ready)) begin
      for (int k = 0; k < 8; k++) n_vld[k] = 1'b0;
      n_ptr  = 0;
      n_hold = 1'b0;
    end else if (!m_hold && i_valid) begin
      int lane;
      lane = auto_en ? m_ptr : int'(s);
      n_lane[lane] = i;
      n_vld[lane]  = 1'b1;
      if (auto_en) n_ptr = (m_ptr + 1) % 8;
      filled = 0;
      for (int k = 0; k < 8; k++) filled += int'(n_vld[k]);
      if (filled == 8) n_hold = 1'b1;
    end
  endtask

  function automatic logic [8*W-1:0] exp_bus();
    logic [8*W-1:0] b;
    for (int k = 0; k < 8; k++) b[k*W +: W] = m_lane[k];
    return b;
  endfunction

  function automatic logic [7:0] exp_vld();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_vld[k];
    return v;
  endfunction

  // One clock: model steps on the edge, outputs are looked at 1 unit later.
  task automatic cycle();
    model_next();
    @(posedge clk);
    m_lane = n_lane;
    m_vld  = n_vld;
    m_ptr  = n_ptr;
    m_hold = n_hold;
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    clr     = 1'b0;
    o_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; i = '0; s = '0; auto_en = 1'b1; idle();
    model_reset();
    #12;
    checks++;
    if (dut_bus !== '0 || lane_vld !== 8'h00 || frame_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got bus=%h vld=%h fv=%b, need all zero", dut_bus, lane_vld, frame_vld);
    end
    checks++;
    if (i_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b need 0", i_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (i_ready !== 1'b1 || frame_vld !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got ready=%b fv=%b need 1/0", i_ready, frame_vld);
    end
  endtask

  task automatic test_auto_fill();
    idle(); auto_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      i = W'(b + 1); i_valid = 1'b1;
      cycle();
      checks++;
      if (lane_vld !== 8'((1 << (b + 1)) - 1)) begin
        errors++;
        $display("FAIL auto_vld beat%0d: got %h need %h", b, lane_vld, 8'((1 << (b + 1)) - 1));
      end
      checks++;
      if (frame_vld !== (b == 7)) begin
        errors++;
        $display("FAIL auto_frame beat%0d: got %b need %b", b, frame_vld, b == 7);
      end
    end
    checks++;
    if (dut_bus !== {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}) begin
      errors++;
      $display("FAIL auto_data: got %h", dut_bus);
    end
    // Still pushing in HOLD: nothing must be taken, frame stays frozen.
    for (int c = 0; c < 3; c++) begin
      i = 16'(($urandom & 32'hFFFF)); i_valid = 1'b1;
      cycle();
      checks++;
      if (i_ready !== 1'b0 || frame_vld !== 1'b1 || dut_bus !== exp_bus() || lane_vld !== 8'hFF) begin
        errors++;
        $display("FAIL hold_frozen c%0d: ready=%b fv=%b vld=%h bus=%h need bus=%h", c, i_ready, frame_vld, lane_vld, dut_bus, exp_bus());
      end
    end
    idle(); o_ready = 1'b1;
    cycle();
    idle();
    checks++;
    if (frame_vld !== 1'b0 || lane_vld !== 8'h00 || i_ready !== 1'b1 || dut_bus !== exp_bus()) begin
      errors++;
      $display("FAIL handoff: fv=%b vld=%h ready=%b bus=%h need 0/00/1 bus=%h", frame_vld, lane_vld, i_ready, dut_bus, exp_bus());
    end
  endtask

  task automatic test_addressed_overwrite();
    int order [9];
    logic [W-1:0] data [9];
    order = '{3, 3, 0, 1, 2, 4, 5, 6, 7};
    idle(); auto_en = 1'b0;
    for (int b = 0; b < 9; b++) begin
      if (b == 0)      data[b] = 16'hAAAA;
      else if (b == 1) data[b] = 16'hBBBB;
      else             data[b] = 16'($urandom);
      i = data[b]; s = 3'(order[b]); i_valid = 1'b1;
      cycle();
      checks++;
      if (frame_vld !== (b == 8) || lane_vld !== exp_vld() || dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL addr beat%0d: fv=%b vld=%h bus=%h need fv=%b vld=%h bus=%h", b, frame_vld, lane_vld, dut_bus, b == 8, exp_vld(), exp_bus());
      end
    end
    idle();
    checks++;
    if (o4 !== 16'hBBBB) begin
      errors++;
      $display("FAIL addr_overwrite: got o4=%h need bbbb", o4);
    end
  endtask

  task automatic test_handoff_collision();
    // Entered in HOLD from the addressed fill.
    o_ready = 1'b1; i_valid = 1'b1; i = 16'h1234; auto_en = 1'b1;
    cycle();
    checks++;
    if (frame_vld !== 1'b0 || lane_vld !== 8'h00 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL collision_state: fv=%b vld=%h ready=%b need 0/00/1", frame_vld, lane_vld, i_ready);
    end
    o_ready = 1'b0;
    cycle();
    idle();
    checks++;
    if (o1 !== 16'h1234 || lane_vld !== 8'h01) begin
      errors++;
      $display("FAIL collision_replay: o1=%h vld=%h need 1234/01", o1, lane_vld);
    end
    clr = 1'b1;
    cycle();
    idle();
  endtask

  task automatic test_stream();
    int cnt = 0, lows = 0, frames = 0;
    bit acc;
    idle(); o_ready = 1'b1; auto_en = 1'b1; i_valid = 1'b1;
    for (int c = 0; c < 60 && cnt < 24; c++) begin
      i = 16'(cnt);
      acc = i_ready;
      if (!acc && cnt > 0) lows++;
      cycle();
      if (acc) cnt++;
      checks++;
      if (dut_bus !== exp_bus() || lane_vld !== exp_vld() || frame_vld !== m_hold) begin
        errors++;
        $display("FAIL stream c%0d: bus=%h vld=%h fv=%b need bus=%h vld=%h fv=%b", c, dut_bus, lane_vld, frame_vld, exp_bus(), exp_vld(), m_hold);
      end
      if (frame_vld === 1'b1) begin
        checks++;
        if (o1 !== 16'(frames * 8)) begin
          errors++;
          $display("FAIL stream_o1 frame%0d: got %0d need %0d", frames, o1, frames * 8);
        end
        frames++;
      end
    end
    checks++;
    if (cnt != 24 || frames != 3 || lows != 2) begin
      errors++;
      $display("FAIL stream_counts: accepted=%0d frames=%0d ready_low=%0d need 24/3/2", cnt, frames, lows);
    end
    idle();
  endtask

  task automatic test_clr_priority();
    logic [W-1:0] v;
    idle(); clr = 1'b1;
    cycle();
    idle(); auto_en = 1'b1;
    for (int b = 0; b < 5; b++) begin
      i = 16'($urandom); i_valid = 1'b1;
      cycle();
    end
    i = 16'hDEAD; i_valid = 1'b1; clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++;
    if (lane_vld !== 8'h00 || frame_vld !== 1'b0 || dut_bus !== exp_bus()) begin
      errors++;
      $display("FAIL clr_drop: vld=%h fv=%b bus=%h need 00/0 bus=%h", lane_vld, frame_vld, dut_bus, exp_bus());
    end
    v = 16'($urandom);
    i = v; i_valid = 1'b1;
    cycle();
    idle();
    checks++;
    if (o1 !== v || lane_vld !== 8'h01) begin
      errors++;
      $display("FAIL clr_ptr: o1=%h vld=%h need %h/01", o1, lane_vld, v);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] v;
    idle(); clr = 1'b1;
    cycle();
    idle(); auto_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      i = 16'($urandom) | 16'h0001; i_valid = 1'b1;
      cycle();
    end
    idle();
    checks++;
    if (frame_vld !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: fv=%b need 1", frame_vld);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_bus !== '0 || lane_vld !== 8'h00 || frame_vld !== 1'b0 || i_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: bus=%h vld=%h fv=%b ready=%b need all 0", dut_bus, lane_vld, frame_vld, i_ready);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = 16'($urandom);
    i = v; i_valid = 1'b1;
    cycle();
    idle();
    checks++;
    if (o1 !== v || lane_vld !== 8'h01 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_resume: o1=%h vld=%h ready=%b need %h/01/1", o1, lane_vld, i_ready, v);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      i       = 16'($urandom);
      i_valid = ($urandom_range(0, 3) != 0);
      auto_en = $urandom_range(0, 1) != 0;
      s       = 3'($urandom_range(0, 7));
      clr     = ($urandom_range(0, 29) == 0);
      o_ready = ($urandom_range(0, 2) == 0);
      cycle();
      checks++;
      if (dut_bus !== exp_bus() || lane_vld !== exp_vld() || frame_vld !== m_hold || i_ready !== !m_hold) begin
        errors++;
        $display("FAIL random c%0d: bus=%h vld=%h fv=%b rdy=%b need bus=%h vld=%h fv=%b", c, dut_bus, lane_vld, frame_vld, i_ready, exp_bus(), exp_vld(), m_hold);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_auto_fill();
    test_addressed_overwrite();
    test_handoff_collision();
    test_stream();
    test_clr_priority();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dmux_16_8w
